accumulator_bank: RTL and testbench
===================================

# accumulator_bank

Parametrised successor of the 16-lane accumulator behind the matrix-multiply unit. It holds DEPTH rows of LANES signed partial sums, ACC_BITS wide, and accepts one MMU output row per cycle in overwrite or accumulate mode, with saturation and read-after-write forwarding. On read-out it requantises each lane to OUT_BITS (arithmetic shift, round, optional ReLU, saturate) for the unified buffer, and can clear the row on read.

## Interface
- LANES, 16: lanes per row.
- IN_BITS, 20: signed width of each incoming MMU lane.
- ACC_BITS, 24: signed accumulator width; must be ≥ IN_BITS.
- OUT_BITS, 8: signed width of each requantised output lane.
- DEPTH, 64: number of rows.
- ADDR_BITS, $clog2(DEPTH): row address width.
- SHIFT_BITS, 5: width of the read-out shift amount.
- clk  in  1  sole clock; rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- wr_valid  in  1  write request this cycle; no backpressure.
- wr_mode  in  1  0 = overwrite, 1 = accumulate.
- wr_addr  in  ADDR_BITS  target row.
- wr_data  in  LANES*IN_BITS  lane i at [i*IN_BITS +: IN_BITS], signed.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_BITS  row to read.
- rd_shift  in  SHIFT_BITS  right-shift amount for requantisation.
- rd_relu  in  1  when 1, clamp negative results to 0.
- rd_clear  in  1  with rd_en, zero the row after reading it.
- rd_valid  out  1  rd_data is valid.
- rd_data  out  LANES*OUT_BITS  lane i at [i*OUT_BITS +: OUT_BITS].
- sat_flag  out  1  sticky: an accumulate or a requantisation saturated.
- clr_drop  out  1  one-cycle pulse: a clear was dropped because of a conflict.
- flag_clr  in  1  clears sat_flag.

## Operation
- Write pipeline, two stages.
  - S1 reads the old row.
  - S2 computes and writes it back at the end of S2.
  - Overwrite stores sign-extend(wr_data lane).
  - Accumulate stores old + sign-extend(lane), saturated to [-2^(ACC_BITS-1), 2^(ACC_BITS-1)-1]; saturation sets sat_flag.
- Forwarding: back-to-back writes to the same row must give results identical to sequential execution. The S2 result is forwarded into S1.
- Read per lane:
  - Compute v = (acc + (rd_shift>0 ? 1<<(rd_shift-1) : 0)) >>> rd_shift in ACC_BITS+1 bits, i.e. round half up.
  - Apply ReLU if rd_relu is set.
  - Saturate to signed OUT_BITS; saturation sets sat_flag.
- Read coherency: a read at cycle T sees every write with wr_valid at cycles ≤ T-1. It does not see a write issued in cycle T, even to the same row.
- rd_clear: queued as an overwrite-with-zero into the write pipeline in the cycle after rd_en.
  - If wr_valid is also high in that cycle, the write proceeds, the clear is dropped, and clr_drop pulses.
- sat_flag priority: if flag_clr and a new saturation occur in the same cycle, set wins.
- Row contents are not reset and are undefined until first written.

## Timing
- Reset values: rd_valid=0, rd_data=0, sat_flag=0, clr_drop=0; pipeline valids cleared.
- Write and clear requests in flight when reset_n asserts are discarded.
- Write latency: wr_valid at T commits to memory at the end of T+1. Throughput is one row per cycle.
- Read latency: rd_en at T gives rd_valid=1 with rd_data at T+2.
  - Fully pipelined: one read per cycle.
  - rd_data holds its value when rd_valid=0.
- Reads and writes are independent and concurrent; there is no stall condition.
- Address wrap: none. Out-of-range addresses (≥ DEPTH when DEPTH is not a power of two) are ignored for writes and return 0 for reads.
- rd_shift ≥ ACC_BITS yields 0 or -1 before ReLU, consistent with the arithmetic shift.

## Structure
- Shared package sa_acc_pkg holds:
  - mode constants ACC_MODE_OVERWRITE=1'b0 and ACC_MODE_ACCUMULATE=1'b1;
  - the default width parameters;
  - lane-slice helper functions.
- One sub-module, acc_requant (one per lane, combinational): shift, round, ReLU, saturate, plus a saturation indicator.
- Storage is a 2-read/1-write register array (one read port each for S1 and the read path).

## Test plan
- Overwrite row 3 with all lanes 100, then read with shift 0 → rd_data lanes all 100 at T+2; sat_flag=0.
- Accumulate 5 to row 7 on four consecutive cycles after an overwrite of 10 → readback 30 (forwarding check).
- Lane value 2^23-1 accumulated with +1 (ACC_BITS=24) → stored value stays 2^23-1; sat_flag=1; flag_clr → sat_flag=0.
- Stored -300, shift 2: without ReLU gives -75; with ReLU gives 0. Stored 1000, shift 2 → 127 (saturated).
- rd_en with rd_clear on row 5 (value 42) → returns 42; a second read returns 0. Repeat with wr_valid high in the clear cycle → clr_drop pulses and the row keeps the write's value.
- reset_n low while a write is in S1 → that write is never committed; all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/sa_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sa_acc_pkg
// Brief    : Shared write modes, default widths and lane-slice helpers for the
//            systolic-array accumulator bank.
// Revision : 1.0 - initial release
// ============================================================================
package sa_acc_pkg;

    localparam logic ACC_MODE_OVERWRITE  = 1'b0;
    localparam logic ACC_MODE_ACCUMULATE = 1'b1;

    localparam int DEF_LANES      = 16;
    localparam int DEF_IN_BITS    = 20;
    localparam int DEF_ACC_BITS   = 24;
    localparam int DEF_OUT_BITS   = 8;
    localparam int DEF_DEPTH      = 64;
    localparam int DEF_SHIFT_BITS = 5;

    // Bit position of the least significant bit of a lane in a packed row.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    function automatic int lane_msb(input int lane, input int width);
        return lane * width + width - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/acc_requant.sv
`default_nettype none
// ============================================================================
// Module   : acc_requant
// Brief    : One-lane requantiser: round-half-up arithmetic shift, optional
//            ReLU and saturation to the output width.
// Revision : 1.0 - initial release
// ============================================================================
module acc_requant #(
    parameter int ACC_BITS   = 24,
    parameter int OUT_BITS   = 8,
    parameter int SHIFT_BITS = 5
) (
    input  logic signed [ACC_BITS-1:0]   i_acc,
    input  logic        [SHIFT_BITS-1:0] i_shift,
    input  logic                         i_relu,
    output logic signed [OUT_BITS-1:0]   o_q,
    output logic                         o_sat
);

    localparam int c_W       = ACC_BITS + 1;
    localparam int c_OUT_MAX = (1 << (OUT_BITS - 1)) - 1;
    localparam logic signed [c_W-1:0] c_HI = c_W'(c_OUT_MAX);
    localparam logic signed [c_W-1:0] c_LO = c_W'(-c_OUT_MAX - 1);

    logic signed [c_W-1:0] w_ext;
    logic signed [c_W-1:0] w_rnd;
    logic signed [c_W-1:0] w_sum;
    logic signed [c_W-1:0] w_shr;
    logic signed [c_W-1:0] w_act;
    logic                  w_hi;
    logic                  w_lo;

    assign w_ext = c_W'(i_acc);

    // The rounding bit is only meaningful while it lands inside the widened
    // word; larger shifts reduce to a plain arithmetic shift (0 or -1).
    always_comb begin
        w_rnd = '0;
        if ((i_shift != '0) && (int'(i_shift) <= ACC_BITS)) begin
            w_rnd = c_W'(1) << (i_shift - SHIFT_BITS'(1));
        end
    end

    assign w_sum = w_ext + w_rnd;
    assign w_shr = w_sum >>> i_shift;
    assign w_act = (i_relu && w_shr[c_W-1]) ? '0 : w_shr;
    assign w_hi  = (w_act > c_HI);
    assign w_lo  = (w_act < c_LO);

    assign o_q   = w_hi ? c_HI[OUT_BITS-1:0] :
                   w_lo ? c_LO[OUT_BITS-1:0] : w_act[OUT_BITS-1:0];
    assign o_sat = w_hi | w_lo;

endmodule
`default_nettype wire

// File: rtl/accumulator_bank.sv
`default_nettype none
// ============================================================================
// Module   : accumulator_bank
// Brief    : DEPTH x LANES signed accumulator with two-stage forwarded write
//            pipeline and requantising, optionally clearing, read path.
// Revision : 1.0 - initial release
// ============================================================================
module accumulator_bank
    import sa_acc_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int IN_BITS    = DEF_IN_BITS,
    parameter int ACC_BITS   = DEF_ACC_BITS,
    parameter int OUT_BITS   = DEF_OUT_BITS,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_BITS  = $clog2(DEPTH),
    parameter int SHIFT_BITS = DEF_SHIFT_BITS
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wr_valid,
    input  logic                      wr_mode,
    input  logic [ADDR_BITS-1:0]      wr_addr,
    input  logic [LANES*IN_BITS-1:0]  wr_data,
    input  logic                      rd_en,
    input  logic [ADDR_BITS-1:0]      rd_addr,
    input  logic [SHIFT_BITS-1:0]     rd_shift,
    input  logic                      rd_relu,
    input  logic                      rd_clear,
    output logic                      rd_valid,
    output logic [LANES*OUT_BITS-1:0] rd_data,
    output logic                      sat_flag,
    output logic                      clr_drop,
    input  logic                      flag_clr
);

    localparam int c_ROW_BITS = LANES * ACC_BITS;
    localparam int c_SUM_W    = ACC_BITS + 1;
    localparam logic signed [ACC_BITS-1:0] c_ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] c_ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

    logic [c_ROW_BITS-1:0] r_mem [DEPTH];

    logic                      w_wr_in_range;
    logic                      w_rd_in_range;
    logic                      w_clr_go;
    logic                      w_s1_valid;
    logic [ADDR_BITS-1:0]      w_s1_addr;
    logic                      w_s1_mode;
    logic [LANES*IN_BITS-1:0]  w_s1_data;
    logic [c_ROW_BITS-1:0]     w_s1_old;

    logic                      r_s2_valid;
    logic [ADDR_BITS-1:0]      r_s2_addr;
    logic                      r_s2_mode;
    logic [LANES*IN_BITS-1:0]  r_s2_data;
    logic [c_ROW_BITS-1:0]     r_s2_old;
    logic [c_ROW_BITS-1:0]     w_s2_row;
    logic [LANES-1:0]          w_acc_sat;

    logic                      r_clr_pend;
    logic [ADDR_BITS-1:0]      r_clr_addr;

    logic [c_ROW_BITS-1:0]     w_rd_row;
    logic                      r_r1_valid;
    logic [c_ROW_BITS-1:0]     r_r1_row;
    logic [SHIFT_BITS-1:0]     r_r1_shift;
    logic                      r_r1_relu;
    logic [LANES*OUT_BITS-1:0] w_rq_data;
    logic [LANES-1:0]          w_rq_sat;
    logic                      w_sat_set;

    assign w_wr_in_range = (int'(wr_addr) < DEPTH);
    assign w_rd_in_range = (int'(rd_addr) < DEPTH);

    // A queued clear borrows the write slot only when no real write wants it.
    assign w_clr_go   = r_clr_pend && !wr_valid;
    assign w_s1_valid = (wr_valid && w_wr_in_range) || w_clr_go;
    assign w_s1_addr  = wr_valid ? wr_addr : r_clr_addr;
    assign w_s1_mode  = wr_valid ? wr_mode : ACC_MODE_OVERWRITE;
    assign w_s1_data  = wr_valid ? wr_data : '0;

    always_comb begin
        w_s1_old = r_mem[w_s1_addr];
        if (r_s2_valid && (r_s2_addr == w_s1_addr)) begin
            w_s1_old = w_s2_row;
        end
    end

    // The read sees the row in S2 so that writes one cycle earlier are visible.
    always_comb begin
        w_rd_row = r_mem[rd_addr];
        if (r_s2_valid && (r_s2_addr == rd_addr)) begin
            w_rd_row = w_s2_row;
        end
        if (!w_rd_in_range) begin
            w_rd_row = '0;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int c_IN_LSB  = lane_lsb(i, IN_BITS);
        localparam int c_ACC_LSB = lane_lsb(i, ACC_BITS);
        localparam int c_OUT_LSB = lane_lsb(i, OUT_BITS);

        logic signed [IN_BITS-1:0]  w_in;
        logic signed [ACC_BITS-1:0] w_old;
        logic signed [ACC_BITS-1:0] w_ext;
        logic signed [ACC_BITS-1:0] w_new;
        logic signed [ACC_BITS:0]   w_sum;
        logic                       w_ovf;

        assign w_in  = r_s2_data[c_IN_LSB +: IN_BITS];
        assign w_old = r_s2_old[c_ACC_LSB +: ACC_BITS];
        assign w_ext = ACC_BITS'(w_in);
        assign w_sum = c_SUM_W'(w_old) + c_SUM_W'(w_ext);
        assign w_ovf = w_sum[ACC_BITS] ^ w_sum[ACC_BITS-1];

        always_comb begin
            w_new = w_ext;
            if (r_s2_mode == ACC_MODE_ACCUMULATE) begin
                if (w_ovf) begin
                    w_new = w_sum[ACC_BITS] ? c_ACC_MIN : c_ACC_MAX;
                end else begin
                    w_new = w_sum[ACC_BITS-1:0];
                end
            end
        end

        assign w_s2_row[c_ACC_LSB +: ACC_BITS] = w_new;
        assign w_acc_sat[i] = (r_s2_mode == ACC_MODE_ACCUMULATE) && w_ovf;

        acc_requant #(
            .ACC_BITS   (ACC_BITS),
            .OUT_BITS   (OUT_BITS),
            .SHIFT_BITS (SHIFT_BITS)
        ) u_requant (
            .i_acc   (r_r1_row[c_ACC_LSB +: ACC_BITS]),
            .i_shift (r_r1_shift),
            .i_relu  (r_r1_relu),
            .o_q     (w_rq_data[c_OUT_LSB +: OUT_BITS]),
            .o_sat   (w_rq_sat[i])
        );
    end

    assign w_sat_set = (r_s2_valid && (|w_acc_sat)) || (r_r1_valid && (|w_rq_sat));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_clr_pend <= 1'b0;
            r_r1_valid <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            sat_flag   <= 1'b0;
            clr_drop   <= 1'b0;
        end else begin
            r_s2_valid <= w_s1_valid;
            r_clr_pend <= rd_en && rd_clear && w_rd_in_range;
            r_r1_valid <= rd_en;
            rd_valid   <= r_r1_valid;
            if (r_r1_valid) begin
                rd_data <= w_rq_data;
            end
            clr_drop <= r_clr_pend && wr_valid;
            if (w_sat_set) begin
                sat_flag <= 1'b1;
            end else if (flag_clr) begin
                sat_flag <= 1'b0;
            end
        end
    end

    // Payload registers are qualified by the valids above and need no reset.
    always_ff @(posedge clk) begin
        r_s2_addr  <= w_s1_addr;
        r_s2_mode  <= w_s1_mode;
        r_s2_data  <= w_s1_data;
        r_s2_old   <= w_s1_old;
        r_clr_addr <= rd_addr;
        r_r1_row   <= w_rd_row;
        r_r1_shift <= rd_shift;
        r_r1_relu  <= rd_relu;
    end

    always_ff @(posedge clk) begin
        if (r_s2_valid) begin
            r_mem[r_s2_addr] <= w_s2_row;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accumulator_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_accumulator_bank
// Brief    : Directed scoreboard bench for accumulator_bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_accumulator_bank;
    import sa_acc_pkg::*;

    localparam int LANES    = 16;
    localparam int IN_BITS  = 20;
    localparam int OUT_BITS = 8;
    localparam int ADDR_W   = 6;
    localparam int SHIFT_W  = 5;
    localparam int IW       = LANES * IN_BITS;
    localparam int OW       = LANES * OUT_BITS;

    typedef struct {
        logic [OW-1:0] data;
        int            cyc;
        string         name;
    } exp_t;

    logic                clk;
    logic                reset_n;
    logic                wr_valid;
    logic                wr_mode;
    logic [ADDR_W-1:0]   wr_addr;
    logic [IW-1:0]       wr_data;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [SHIFT_W-1:0]  rd_shift;
    logic                rd_relu;
    logic                rd_clear;
    logic                rd_valid;
    logic [OW-1:0]       rd_data;
    logic                sat_flag;
    logic                clr_drop;
    logic                flag_clr;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t exp_q[$];

    accumulator_bank dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_valid (wr_valid),
        .wr_mode  (wr_mode),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_shift (rd_shift),
        .rd_relu  (rd_relu),
        .rd_clear (rd_clear),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .sat_flag (sat_flag),
        .clr_drop (clr_drop),
        .flag_clr (flag_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [IW-1:0] in_bus(input int base, input int step);
        logic [IW-1:0] b;
        for (int i = 0; i < LANES; i++) b[i*IN_BITS +: IN_BITS] = IN_BITS'(base + step * i);
        return b;
    endfunction

    function automatic logic [OW-1:0] uni_out(input int v);
        logic [OW-1:0] b;
        for (int i = 0; i < LANES; i++) b[i*OUT_BITS +: OUT_BITS] = OUT_BITS'(v);
        return b;
    endfunction

    // Integer reference for round-half-up shift, ReLU and 8-bit clamp.
    function automatic logic [OW-1:0] rq_bus(input int base, input int step, input int sh, input bit relu);
        logic [OW-1:0] b;
        longint v;
        for (int i = 0; i < LANES; i++) begin
            v = longint'(base + step * i);
            if (sh > 0) v = v + (longint'(1) << (sh - 1));
            v = v >>> sh;
            if (relu && v < 0) v = 0;
            if (v > 127) v = 127;
            if (v < -128) v = -128;
            b[i*OUT_BITS +: OUT_BITS] = v[7:0];
        end
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        wr_valid = 1'b0; wr_mode = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0; rd_shift = '0; rd_relu = 1'b0; rd_clear = 1'b0;
        flag_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input int addr, input logic mode, input int base, input int step = 0);
        wr_valid = 1'b1;
        wr_mode  = mode;
        wr_addr  = ADDR_W'(addr);
        wr_data  = in_bus(base, step);
    endtask

    task automatic rd(input int addr, input int sh, input bit relu, input bit clr,
                      input logic [OW-1:0] expd, input string nm);
        exp_t e;
        rd_en    = 1'b1;
        rd_addr  = ADDR_W'(addr);
        rd_shift = SHIFT_W'(sh);
        rd_relu  = relu;
        rd_clear = clr;
        e.data = expd;
        e.cyc  = cyc + 2;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, expv);
        end
    endtask

    // Monitor: every presented read result must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && rd_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got data %h at cycle %0d, expected no read", rd_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rd_data !== e.data || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL %s: got %h at cycle %0d expected %h at cycle %0d",
                             e.name, rd_data, cyc, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        int waited;
        reset_n = 1'b0;
        wr_valid = 1'b0; wr_mode = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0; rd_shift = '0; rd_relu = 1'b0; rd_clear = 1'b0;
        flag_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, '0);
        chk1("rst_sat_flag", sat_flag, 1'b0);
        chk1("rst_clr_drop", clr_drop, 1'b0);
        @(negedge clk) reset_n = 1'b1;
        tick();

        // Overwrite and plain readback, then data hold.
        wr(3, ACC_MODE_OVERWRITE, 100); tick();
        rd(3, 0, 1'b0, 1'b0, uni_out(100), "rd_row3"); tick();
        idle(3);
        chk1("hold_rd_valid", rd_valid, 1'b0);
        chk("hold_rd_data", rd_data, uni_out(100));
        chk1("sat_after_row3", sat_flag, 1'b0);

        // Back-to-back accumulates, then coherency of a same-cycle write.
        wr(7, ACC_MODE_OVERWRITE, 10); tick();
        repeat (4) begin wr(7, ACC_MODE_ACCUMULATE, 5); tick(); end
        rd(7, 0, 1'b0, 1'b0, uni_out(30), "rd_fwd"); tick();
        wr(7, ACC_MODE_ACCUMULATE, 5);
        rd(7, 0, 1'b0, 1'b0, uni_out(30), "rd_same_cycle"); tick();
        idle(2);
        rd(7, 0, 1'b0, 1'b0, uni_out(35), "rd_after_same"); tick();
        idle(3);

        // Positive saturation: build 2^23-1, then add 1.
        wr(9, ACC_MODE_OVERWRITE, 524287); tick();
        repeat (15) begin wr(9, ACC_MODE_ACCUMULATE, 524287); tick(); end
        wr(9, ACC_MODE_ACCUMULATE, 15); tick();
        idle(2);
        chk1("sat_before_pos", sat_flag, 1'b0);
        wr(9, ACC_MODE_ACCUMULATE, 1); tick();
        idle(2);
        chk1("sat_acc_pos", sat_flag, 1'b1);
        flag_clr = 1'b1; tick();
        chk1("sat_cleared", sat_flag, 1'b0);
        rd(9, 17, 1'b0, 1'b0, uni_out(64), "rd_pos_clamped"); tick();
        idle(3);
        chk1("sat_after_rd9", sat_flag, 1'b0);

        // Negative saturation with flag_clr landing on the saturating cycle.
        wr(10, ACC_MODE_OVERWRITE, -524288); tick();
        repeat (15) begin wr(10, ACC_MODE_ACCUMULATE, -524288); tick(); end
        idle(2);
        chk1("sat_before_neg", sat_flag, 1'b0);
        wr(10, ACC_MODE_ACCUMULATE, -1); tick();
        flag_clr = 1'b1; tick();
        chk1("sat_set_wins", sat_flag, 1'b1);
        flag_clr = 1'b1; tick();
        chk1("sat_cleared2", sat_flag, 1'b0);
        rd(10, 17, 1'b0, 1'b0, uni_out(-64), "rd_neg_clamped"); tick();
        idle(3);

        // Requantisation corner cases.
        wr(12, ACC_MODE_OVERWRITE, -300); tick();
        wr(13, ACC_MODE_OVERWRITE, 1000); tick();
        rd(12, 2, 1'b0, 1'b0, uni_out(-75), "rq_neg"); tick();
        rd(12, 2, 1'b1, 1'b0, uni_out(0), "rq_relu"); tick();
        rd(12, 31, 1'b0, 1'b0, uni_out(-1), "rq_bigshift"); tick();
        idle(3);
        chk1("sat_rq_none", sat_flag, 1'b0);
        rd(13, 2, 1'b0, 1'b0, uni_out(127), "rq_sat"); tick();
        idle(3);
        chk1("sat_rq", sat_flag, 1'b1);
        flag_clr = 1'b1; tick();
        wr(20, ACC_MODE_OVERWRITE, -40, 13); tick();
        rd(20, 1, 1'b0, 1'b0, rq_bus(-40, 13, 1, 1'b0), "rq_ramp"); tick();
        rd(20, 3, 1'b1, 1'b0, rq_bus(-40, 13, 3, 1'b1), "rq_ramp_relu"); tick();
        idle(3);

        // Clear-on-read, then a clear that loses to a write.
        wr(5, ACC_MODE_OVERWRITE, 42); tick();
        rd(5, 0, 1'b0, 1'b1, uni_out(42), "rd_clr_first"); tick();
        idle(3);
        chk1("clr_drop_quiet", clr_drop, 1'b0);
        rd(5, 0, 1'b0, 1'b0, uni_out(0), "rd_after_clr"); tick();
        idle(3);
        wr(5, ACC_MODE_OVERWRITE, 42); tick();
        rd(5, 0, 1'b0, 1'b1, uni_out(42), "rd_clr_second"); tick();
        wr(5, ACC_MODE_OVERWRITE, 77); tick();
        chk1("clr_drop_pulse", clr_drop, 1'b1);
        tick();
        chk1("clr_drop_end", clr_drop, 1'b0);
        idle(2);
        rd(5, 0, 1'b0, 1'b0, uni_out(77), "rd_keep_write"); tick();
        idle(3);

        // Asynchronous reset with a write sitting in S1.
        rd_en = 1'b1; rd_addr = ADDR_W'(13); rd_shift = SHIFT_W'(2); tick();
        tick();
        chk1("pre_rst_valid", rd_valid, 1'b1);
        chk("pre_rst_data", rd_data, uni_out(127));
        chk1("pre_rst_sat", sat_flag, 1'b1);
        wr(3, ACC_MODE_OVERWRITE, 55);
        #2;
        reset_n = 1'b0;
        #1;
        chk1("async_rd_valid", rd_valid, 1'b0);
        chk("async_rd_data", rd_data, '0);
        chk1("async_sat_flag", sat_flag, 1'b0);
        chk1("async_clr_drop", clr_drop, 1'b0);
        tick();
        tick();
        @(negedge clk) reset_n = 1'b1;
        tick();
        rd(3, 0, 1'b0, 1'b0, uni_out(100), "rd_rst_discard"); tick();
        idle(3);

        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d reads outstanding, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
